// File: rtl/hilo_acc_if.sv
// ----------------------------------------------------------------------------
// hilo_acc_if -- bus bundle for the HI/LO accumulator register pair.
//
// Groups every non-clock, non-reset signal of hilo_acc.
//   master : driver side (testbench or surrounding core)
//   slave  : the hilo_acc block itself
//
// Signals
//   we_hi / we_lo   direct write enables for HI / LO
//   hi_i / lo_i     direct write data (DATA_W each)
//   acc_valid       accumulate request
//   acc_op          0 = add, 1 = subtract
//   acc_i           accumulate operand (2*DATA_W, upper half aligns with HI)
//   flush           cancels an in-flight accumulate, blocks acceptance
//   acc_ready       block is idle and can accept an accumulate this cycle
//   acc_done        one-cycle pulse after an accumulate commits
//   hi_o / lo_o     registered HI / LO
//   hi_fwd_o/lo_fwd_o  direct-write bypassed HI / LO
// ----------------------------------------------------------------------------
interface hilo_acc_if #(
    parameter int DATA_W = 32
);
    logic                  we_hi;
    logic                  we_lo;
    logic [DATA_W-1:0]     hi_i;
    logic [DATA_W-1:0]     lo_i;
    logic                  acc_valid;
    logic                  acc_op;
    logic [2*DATA_W-1:0]   acc_i;
    logic                  flush;
    logic                  acc_ready;
    logic                  acc_done;
    logic [DATA_W-1:0]     hi_o;
    logic [DATA_W-1:0]     lo_o;
    logic [DATA_W-1:0]     hi_fwd_o;
    logic [DATA_W-1:0]     lo_fwd_o;

    modport master (
        output we_hi, we_lo, hi_i, lo_i, acc_valid, acc_op, acc_i, flush,
        input  acc_ready, acc_done, hi_o, lo_o, hi_fwd_o, lo_fwd_o
    );

    modport slave (
        input  we_hi, we_lo, hi_i, lo_i, acc_valid, acc_op, acc_i, flush,
        output acc_ready, acc_done, hi_o, lo_o, hi_fwd_o, lo_fwd_o
    );
endinterface

// File: rtl/hilo_acc.sv
// ----------------------------------------------------------------------------
// hilo_acc -- HI/LO register pair with direct writes and a two-state
// accumulate engine ({HI,LO} +/- operand, modulo 2^(2*DATA_W)).
//
// Ports
//   clk   single clock, all state updates on the rising edge
//   rst   asynchronous, active-high reset
//   bus   hilo_acc_if.slave (see hilo_acc_if.sv for the signal list)
//
// Parameters
//   DATA_W  width of each of HI and LO
//   ACC_EN  0 removes the accumulate path: FSM stays IDLE, acc_ready = 0,
//           acc_done = 0
//
// Timing: an accumulate accepted at edge N (IDLE, acc_valid, !flush) spends
// one cycle in EXEC and commits at edge N+1, where acc_done is also raised.
// ----------------------------------------------------------------------------
module hilo_acc #(
    parameter int DATA_W = 32,
    parameter int ACC_EN = 1
) (
    input  logic      clk,
    input  logic      rst,
    hilo_acc_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;

    localparam bit ACC_ON = (ACC_EN != 0);

    state_e                state_q, state_d;
    logic [DATA_W-1:0]     hi_q, hi_d;
    logic [DATA_W-1:0]     lo_q, lo_d;
    logic                  op_q;
    logic [2*DATA_W-1:0]   opnd_q;
    logic                  done_q;

    logic                  load;    // capture operand, enter EXEC
    logic                  commit;  // write accumulate result this edge
    logic [2*DATA_W-1:0]   acc_cur;
    logic [2*DATA_W-1:0]   acc_res;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ACC_ON && bus.acc_valid && !bus.flush) begin
                    load    = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // EXEC always lasts one cycle; flush only cancels the write.
                state_d = IDLE;
                commit  = !bus.flush;
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Accumulate datapath. Uses registered {HI,LO} only, so a direct write
    // in the EXEC cycle never feeds the sum.
    // ------------------------------------------------------------------
    assign acc_cur = {hi_q, lo_q};
    assign acc_res = op_q ? (acc_cur - opnd_q) : (acc_cur + opnd_q);

    // Direct writes win per half; the unwritten half takes the commit.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (commit) begin
            hi_d = acc_res[2*DATA_W-1:DATA_W];
            lo_d = acc_res[DATA_W-1:0];
        end
        if (bus.we_hi) hi_d = bus.hi_i;
        if (bus.we_lo) lo_d = bus.lo_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            op_q   <= 1'b0;
            opnd_q <= '0;
            done_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= commit;
            if (load) begin
                op_q   <= bus.acc_op;
                opnd_q <= bus.acc_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Forwarding covers direct writes only, never an in-flight
    // accumulate.
    // ------------------------------------------------------------------
    assign bus.acc_ready = ACC_ON && (state_q == IDLE);
    assign bus.acc_done  = done_q;
    assign bus.hi_o      = hi_q;
    assign bus.lo_o      = lo_q;
    assign bus.hi_fwd_o  = bus.we_hi ? bus.hi_i : hi_q;
    assign bus.lo_fwd_o  = bus.we_lo ? bus.lo_i : lo_q;

endmodule

// File: doc/hilo_acc.md
HILO_ACC -- requirements
Module: hilo_acc

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of each of HI and LO.
REQ-002 SHALL have parameter ACC_EN, default 1; 0 removes accumulate datapath, acc_ready tied 0.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 we_hi  input  1  direct write enable for HI.
REQ-006 we_lo  input  1  direct write enable for LO.
REQ-007 hi_i  input  DATA_W  direct write data for HI.
REQ-008 lo_i  input  DATA_W  direct write data for LO.
REQ-009 acc_valid  input  1  accumulate request.
REQ-010 acc_op  input  1  0 = add, 1 = subtract.
REQ-011 acc_i  input  2*DATA_W  accumulate operand; upper half aligns with HI.
REQ-012 flush  input  1  cancels any in-flight accumulate.
REQ-013 acc_ready  output  1  high when a new accumulate is accepted this cycle.
REQ-014 acc_done  output  1  one-cycle pulse in the cycle after an accumulate commits.
REQ-015 hi_o  output  DATA_W  registered HI.
REQ-016 lo_o  output  DATA_W  registered LO.
REQ-017 hi_fwd_o  output  DATA_W  bypassed HI: hi_i when we_hi, else hi_o (combinational).
REQ-018 lo_fwd_o  output  DATA_W  bypassed LO: lo_i when we_lo, else lo_o (combinational).

Function
REQ-019 Direct writes SHALL update HI and LO independently, visible on hi_o/lo_o one cycle after the enable.
REQ-020 Accumulate SHALL be a two-state FSM: IDLE, EXEC.
REQ-021 IDLE: acc_ready = 1; acc_valid & !flush registers acc_op and acc_i, moves to EXEC.
REQ-022 EXEC: acc_ready = 0; at the closing edge {HI,LO} <= {HI,LO} +/- operand, modulo 2^(2*DATA_W), carry/borrow crosses from LO into HI, overflow discarded; return to IDLE.
REQ-023 Accumulate result SHALL be visible on hi_o/lo_o two cycles after acceptance; acc_done high in that same cycle.
REQ-024 acc_valid while acc_ready = 0 SHALL be ignored, with no queuing.
REQ-025 EXEC SHALL use {HI,LO} as registered at the start of the EXEC cycle, not a same-cycle direct write.
REQ-026 Simultaneous direct write and accumulate commit: written halves take direct data; unwritten halves take accumulate result.
REQ-027 flush in EXEC SHALL suppress the commit, suppress acc_done and return to IDLE.
REQ-028 flush in IDLE SHALL block acceptance that cycle; direct writes are unaffected by flush.
REQ-029 hi_fwd_o/lo_fwd_o SHALL NOT forward in-flight accumulate results.
REQ-030 ACC_EN = 0: FSM stays in IDLE, acc_done constant 0, acc_valid ignored.

Reset
REQ-031 rst high SHALL immediately clear hi_o and lo_o to 0, FSM to IDLE and acc_done to 0, independent of clk.
REQ-032 rst asserted during EXEC SHALL abandon the accumulate with no commit.
REQ-033 In the first edge after rst deasserts, requests SHALL be accepted normally.

Verification (DATA_W = 32)
REQ-034 Reset, then we_hi = 1 with hi_i = 0x12345678 and we_lo = 0 -> hi_o = 0x12345678 and lo_o = 0 next cycle; hi_fwd_o = 0x12345678 in the write cycle.
REQ-035 LO = 0xFFFFFFFF, HI = 0; add acc_i = 1 -> after 2 cycles HI = 1, LO = 0, acc_done pulses once.
REQ-036 HI = LO = 0; subtract acc_i = 1 -> HI = LO = 0xFFFFFFFF (wrap); second acc_valid in the EXEC cycle ignored.
REQ-037 Accumulate commit cycle coincides with we_lo = 1, lo_i = 0xA5A5A5A5 -> LO = 0xA5A5A5A5, HI = accumulated value.
REQ-038 flush or rst asserted in EXEC -> HI/LO unchanged (rst: 0), no acc_done, acc_ready = 1 next cycle.
